// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 8;
    localparam logic [INSTR_W-1:0] NOP = 32'h8b1f03ff;
    typedef enum logic {BUBBLE, RUN} fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register with async reset, load enable and reset value.
module pc_reg #(
    parameter int N = 64,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and IF/ID pipeline register; optional fetch counter
// enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int N = 64,
    parameter logic [N-1:0] INIT_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               PCSrc,
    input  logic [N-1:0]       PCBranch,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [N-1:0]       pc_out,
    output logic               valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);
    logic [N-1:0] pc;
    fetch_state_e state;
    logic load;
    assign load = !flush && !stall;
    // a redirect overrides stall so a taken branch is never lost
    pc_reg #(.N(N), .RST_VAL(INIT_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .en(PCSrc || !stall),
        .d(PCSrc ? PCBranch : pc + N'(4)),
        .q(pc)
    );
    assign imem_addr = pc[IMEM_AW+1:2];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= BUBBLE;
            instr_out <= NOP;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            state <= (state == BUBBLE) ? RUN : state;
            if (flush) begin
                instr_out <= NOP;
                valid_out <= 1'b0;
            end else if (!stall) begin
                instr_out <= instr_in;
                pc_out    <= pc;
                valid_out <= 1'b1;
            end
        end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) fetch_count <= '0;
        else if (load) fetch_count <= fetch_count + 32'd1;
`endif
endmodule
